// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Issues one outstanding request to
//               instruction memory, holds the IF/ID register, absorbs a single
//               response in a skid buffer while decode stalls, and discards
//               in-flight fetches on a redirect (flush).
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
    parameter int size = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [size-1:0] PC_Addr,
    input  logic            flush,
    input  logic            stall,
    output logic            pc_en,
    output logic            imem_req,
    output logic [size-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     instruction,
    output logic [size-1:0] PC_ID,
    output logic            valid_ID
);

    localparam logic [2:0]  c_IDLE = 3'd0;
    localparam logic [2:0]  c_REQ  = 3'd1;
    localparam logic [2:0]  c_WAIT = 3'd2;
    localparam logic [2:0]  c_DROP = 3'd3;
    localparam logic [2:0]  c_FULL = 3'd4;
    localparam logic [31:0] c_NOP  = 32'h0000_0013;

    logic [2:0]      r_state;
    logic [2:0]      w_next;
    logic            r_drop;
    logic            r_pc_en;
    logic [size-1:0] r_addr;
    logic [31:0]     r_instr;
    logic [size-1:0] r_pc_id;
    logic            r_valid;
    logic [31:0]     r_skid_data;
    logic [size-1:0] r_skid_addr;

    logic            w_load_mem;
    logic            w_to_skid;
    logic            w_load_skid;
    logic            w_enter_req;
    logic            w_imem_req;

    // A response can go straight to IF/ID only if decode will take the current word
    assign w_load_mem  = (r_state == c_WAIT) && imem_rvalid && !flush && (!stall || !r_valid);
    assign w_to_skid   = (r_state == c_WAIT) && imem_rvalid && !flush && stall && r_valid;
    assign w_load_skid = (r_state == c_FULL) && !flush && !stall;
    assign w_enter_req = (w_next == c_REQ) && (r_state != c_REQ);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; a grant that coincides with a flush is treated as stale
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: w_next = c_REQ;
            c_REQ: begin
                if (imem_gnt) begin
                    w_next = (r_drop || flush) ? c_DROP : c_WAIT;
                end
            end
            c_WAIT: begin
                if (flush) begin
                    w_next = imem_rvalid ? c_REQ : c_DROP;
                end else if (imem_rvalid) begin
                    w_next = (stall && r_valid) ? c_FULL : c_REQ;
                end
            end
            c_DROP: begin
                if (imem_rvalid) begin
                    w_next = c_REQ;
                end
            end
            c_FULL: begin
                if (flush || !stall) begin
                    w_next = c_REQ;
                end
            end
            default: w_next = c_IDLE;
        endcase
    end

    // Output decode: the request is valid for every cycle spent in REQ
    always_comb begin
        w_imem_req = 1'b0;
        if (r_state == c_REQ) begin
            w_imem_req = 1'b1;
        end
    end

    // Address capture and PC-advance pulse on each entry into REQ
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr  <= '0;
            r_pc_en <= 1'b0;
        end else begin
            r_pc_en <= w_enter_req;
            if (w_enter_req) begin
                r_addr <= PC_Addr;
            end
        end
    end

    // Drop flag remembers a flush seen while the request still awaits its grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_drop <= 1'b0;
        end else begin
            r_drop <= (r_state == c_REQ) && !imem_gnt && (r_drop || flush);
        end
    end

    // Skid buffer catches a response that arrives while decode is stalled
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skid_data <= '0;
            r_skid_addr <= '0;
        end else if (w_to_skid) begin
            r_skid_data <= imem_rdata;
            r_skid_addr <= r_addr;
        end
    end

    // IF/ID register: flush kills, loads fill, consumption empties to a NOP
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_instr <= c_NOP;
            r_pc_id <= '0;
            r_valid <= 1'b0;
        end else if (flush) begin
            r_instr <= c_NOP;
            r_valid <= 1'b0;
        end else if (w_load_mem) begin
            r_instr <= imem_rdata;
            r_pc_id <= r_addr;
            r_valid <= 1'b1;
        end else if (w_load_skid) begin
            r_instr <= r_skid_data;
            r_pc_id <= r_skid_addr;
            r_valid <= 1'b1;
        end else if (!stall) begin
            r_instr <= c_NOP;
            r_valid <= 1'b0;
        end
    end

    assign pc_en       = r_pc_en;
    assign imem_req    = w_imem_req;
    assign imem_addr   = r_addr;
    assign instruction = r_instr;
    assign PC_ID       = r_pc_id;
    assign valid_ID    = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Bench for fetch_stage. The bench plays PC and instruction
//               memory; the expected decode stream is the program-order
//               address sequence, restarted at each redirect target.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] c_NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] PC_Addr;
    logic        flush;
    logic        stall;
    logic        pc_en;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] PC_ID;
    logic        valid_ID;

    always #5 clk = ~clk;

    fetch_stage #(.size(32)) dut (
        .clk         (clk),
        .reset       (rst_n),
        .PC_Addr     (PC_Addr),
        .flush       (flush),
        .stall       (stall),
        .pc_en       (pc_en),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .PC_ID       (PC_ID),
        .valid_ID    (valid_ID)
    );

    int checks   = 0;
    int failures = 0;
    int consumed = 0;

    // Scoreboard: addresses the decoder must receive, in order
    logic [31:0] exp_q[$];
    logic [31:0] next_push;

    // Environment state
    logic        drv_en = 1'b0;
    logic        mon_en = 1'b0;
    logic        zw     = 1'b0;
    logic [31:0] pc_reg;
    logic        last_flush, last_pc_en, last_req, last_gnt, last_rvalid;
    logic [31:0] last_target, last_pc_addr, last_addr;
    logic        pending;
    logic [31:0] paddr;
    int          pdelay;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h0123_4567;
    endfunction

    task automatic check_reset_values(input string tag);
        check({tag, "_imem_req"},    {31'd0, imem_req}, 32'd0);
        check({tag, "_imem_addr"},   imem_addr,         32'd0);
        check({tag, "_pc_en"},       {31'd0, pc_en},    32'd0);
        check({tag, "_instruction"}, instruction,       c_NOP);
        check({tag, "_PC_ID"},       PC_ID,             32'd0);
        check({tag, "_valid_ID"},    {31'd0, valid_ID}, 32'd0);
    endtask

    // Driver: PC model, memory model and random decode/redirect stimulus
    initial begin
        logic [31:0] target;
        forever begin
            @(posedge clk);
            #3;
            if (drv_en) begin
                if (last_flush)      pc_reg = last_target;
                else if (last_pc_en) pc_reg = last_pc_addr + 32'd4;
                if (last_rvalid) pending = 1'b0;
                if (last_req && last_gnt) begin
                    pending = 1'b1;
                    paddr   = last_addr;
                    pdelay  = zw ? 0 : int'($urandom_range(0, 3));
                end
                if (last_req && !last_gnt && imem_req)
                    check("imem_addr_stable", imem_addr, last_addr);

                target  = $urandom & 32'hFFFF_FFFC;
                flush   = zw ? 1'b0 : ($urandom_range(0, 15) == 0);
                stall   = zw ? 1'b0 : ($urandom_range(0, 3) == 0);
                PC_Addr = flush ? target : pc_reg;
                if (imem_req) imem_gnt = zw ? 1'b1 : ($urandom_range(0, 2) == 0);
                else          imem_gnt = ($urandom_range(0, 7) == 0);
                if (pending && pdelay == 0) begin
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(paddr);
                end else begin
                    imem_rvalid = 1'b0;
                    imem_rdata  = $urandom;
                    if (pending) pdelay--;
                end

                if (flush) begin
                    exp_q.delete();
                    next_push = target;
                end
                while (exp_q.size() < 8) begin
                    exp_q.push_back(next_push);
                    next_push += 32'd4;
                end

                last_flush   = flush;
                last_target  = target;
                last_pc_en   = pc_en;
                last_pc_addr = PC_Addr;
                last_req     = imem_req;
                last_gnt     = imem_gnt;
                last_addr    = imem_addr;
                last_rvalid  = imem_rvalid;
            end
        end
    end

    // Monitor: every word the decoder takes is popped and compared
    initial begin
        logic [31:0] a;
        forever begin
            @(posedge clk);
            #7;
            if (mon_en && rst_n) begin
                if (valid_ID && !stall && !flush) begin
                    consumed++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL scoreboard_empty: got PC_ID %h with nothing expected", PC_ID);
                    end else begin
                        a = exp_q.pop_front();
                        check("PC_ID", PC_ID, a);
                        check("instruction", instruction, mem_word(a));
                    end
                end
                if (!valid_ID) check("nop_when_invalid", instruction, c_NOP);
            end
        end
    end

    initial begin
        int c0;
        rst_n       = 1'b0;
        PC_Addr     = '0;
        flush       = 1'b0;
        stall       = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;

        repeat (3) @(posedge clk);
        #3;
        check_reset_values("reset");

        // First fetch after reset: zero-wait memory at address 0
        rst_n = 1'b1;
        @(posedge clk); #3;
        check("e1_pc_en",     {31'd0, pc_en},    32'd1);
        check("e1_imem_req",  {31'd0, imem_req}, 32'd1);
        check("e1_imem_addr", imem_addr,         32'd0);
        imem_gnt = 1'b1;
        @(posedge clk); #3;
        check("e2_imem_req",  {31'd0, imem_req}, 32'd0);
        check("e2_pc_en",     {31'd0, pc_en},    32'd0);
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        PC_Addr     = 32'd4;
        @(posedge clk); #3;
        check("e3_valid_ID",    {31'd0, valid_ID}, 32'd1);
        check("e3_instruction", instruction,       32'h0050_0093);
        check("e3_PC_ID",       PC_ID,             32'd0);
        check("e3_pc_en",       {31'd0, pc_en},    32'd1);
        check("e3_imem_addr",   imem_addr,         32'd4);
        imem_rvalid = 1'b0;
        imem_gnt    = 1'b1;
        stall       = 1'b1;
        @(posedge clk); #3;
        check("e4_imem_req",    {31'd0, imem_req}, 32'd0);
        check("e4_valid_hold",  {31'd0, valid_ID}, 32'd1);
        check("e4_instr_hold",  instruction,       32'h0050_0093);
        imem_gnt = 1'b0;

        // Asynchronous reset while a response is outstanding
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        @(posedge clk); #3;
        check_reset_values("reset_rvalid");
        imem_rvalid = 1'b0;
        stall       = 1'b0;
        PC_Addr     = '0;

        // Randomized run against the program-order model
        exp_q.delete();
        next_push    = '0;
        pc_reg       = '0;
        last_flush   = 1'b0;
        last_pc_en   = 1'b0;
        last_req     = 1'b0;
        last_gnt     = 1'b0;
        last_rvalid  = 1'b0;
        last_target  = '0;
        last_pc_addr = '0;
        last_addr    = '0;
        pending      = 1'b0;
        paddr        = '0;
        pdelay       = 0;
        @(posedge clk); #1;
        rst_n  = 1'b1;
        drv_en = 1'b1;
        mon_en = 1'b1;
        repeat (1500) @(posedge clk);

        // Zero-wait memory, no stall: one instruction every two cycles
        zw = 1'b1;
        repeat (20) @(posedge clk);
        c0 = consumed;
        repeat (40) @(posedge clk);
        check("throughput", consumed - c0, 32'd20);
        zw = 1'b0;

        repeat (500) @(posedge clk);
        check("progress", {31'd0, (consumed >= 100)}, 32'd1);
        drv_en = 1'b0;
        mon_en = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
